// File: rtl/systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_ctrl
// Brief    : Job sequencer for a weight-stationary systolic array. It loads the
//            weight tile, skews activations in and deskews bottom-row results.
//            Optional build macro PERF_CNT_EN adds perf_cycles/perf_stalls.
// Revision : 1.0
// ============================================================================
module systolic_ctrl #(
    parameter int ARR_SIZE      = 4,
    parameter int HORIZONTAL_BW = 16,
    parameter int VERTICAL_BW   = 32,
    parameter int KW            = 16,
    parameter int OUT_LAT       = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [KW-1:0]                     k_len,
    output logic                              busy,
    output logic                              done,
    input  logic                              w_valid,
    output logic                              w_ready,
    input  logic [ARR_SIZE*HORIZONTAL_BW-1:0] w_data,
    input  logic                              a_valid,
    output logic                              a_ready,
    input  logic [ARR_SIZE*HORIZONTAL_BW-1:0] a_data,
    output logic                              arr_mode,
    output logic                              arr_rst,
    output logic [ARR_SIZE*HORIZONTAL_BW-1:0] arr_vert,
    output logic [ARR_SIZE*HORIZONTAL_BW-1:0] arr_horiz,
    input  logic [ARR_SIZE*VERTICAL_BW-1:0]   arr_op,
    output logic                              res_valid,
    output logic [ARR_SIZE*VERTICAL_BW-1:0]   res_data
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]                       perf_cycles,
    output logic [31:0]                       perf_stalls
`endif
);

    localparam int c_TAG_LAT = OUT_LAT + ARR_SIZE - 1;
    localparam int c_HW      = ARR_SIZE * HORIZONTAL_BW;
    localparam int c_VW      = ARR_SIZE * VERTICAL_BW;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_LOAD   = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [KW-1:0]       r_klen;
    logic [KW-1:0]       r_cnt;
    logic [c_TAG_LAT-1:0] r_tag;
    logic                w_w_acc;
    logic                w_a_acc;
    logic                w_last_w;
    logic                w_last_a;
    logic                w_tag_empty;
    logic [c_HW-1:0]     w_inj;
    logic [c_VW-1:0]     w_aligned;

    assign w_w_acc     = (r_state == S_LOAD) && w_valid;
    assign w_a_acc     = (r_state == S_STREAM) && a_valid;
    assign w_last_w    = w_w_acc && (r_cnt == KW'(ARR_SIZE - 1));
    assign w_last_a    = w_a_acc && (r_cnt == (r_klen - KW'(1)));
    assign w_tag_empty = ~|r_tag;
    // Stream cycles without a beat inject zeros so the skew lines keep moving.
    assign w_inj       = w_a_acc ? a_data : '0;

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        w_ready     = 1'b0;
        a_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_CLR;
            end
            S_CLR: begin
                busy        = 1'b1;
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                busy    = 1'b1;
                w_ready = 1'b1;
                if (w_last_w) w_state_nxt = (r_klen == '0) ? S_DRAIN : S_STREAM;
            end
            S_STREAM: begin
                busy    = 1'b1;
                a_ready = 1'b1;
                if (w_last_a) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_tag_empty) begin
                    done        = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_klen  <= '0;
            r_cnt   <= '0;
            r_tag   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) && start) r_klen <= k_len;
            if (w_last_w || w_last_a || (r_state == S_CLR)) r_cnt <= '0;
            else if (w_w_acc || w_a_acc) r_cnt <= r_cnt + KW'(1);
            r_tag <= {r_tag[c_TAG_LAT-2:0], w_a_acc};
        end
    end

    assign arr_mode  = w_w_acc;
    assign arr_vert  = w_w_acc ? w_data : '0;
    assign arr_rst   = !rst || (r_state == S_CLR);
    assign res_valid = r_tag[c_TAG_LAT-1];
    assign res_data  = res_valid ? w_aligned : '0;

    generate
        for (genvar gi = 0; gi < ARR_SIZE; gi++) begin : g_skew
            if (gi == 0) begin : g_direct
                assign arr_horiz[gi*HORIZONTAL_BW +: HORIZONTAL_BW] = w_inj[gi*HORIZONTAL_BW +: HORIZONTAL_BW];
            end else begin : g_delay
                logic [HORIZONTAL_BW-1:0] r_dl [gi];
                always_ff @(posedge clk) begin
                    if (!rst) begin
                        for (int d = 0; d < gi; d++) r_dl[d] <= '0;
                    end else begin
                        r_dl[0] <= w_inj[gi*HORIZONTAL_BW +: HORIZONTAL_BW];
                        for (int d = 1; d < gi; d++) r_dl[d] <= r_dl[d-1];
                    end
                end
                assign arr_horiz[gi*HORIZONTAL_BW +: HORIZONTAL_BW] = r_dl[gi-1];
            end
        end

        // Column j leaves the array j cycles after column 0; hold earlier columns back.
        for (genvar gj = 0; gj < ARR_SIZE; gj++) begin : g_deskew
            localparam int c_D = ARR_SIZE - 1 - gj;
            if (c_D == 0) begin : g_direct
                assign w_aligned[gj*VERTICAL_BW +: VERTICAL_BW] = arr_op[gj*VERTICAL_BW +: VERTICAL_BW];
            end else begin : g_delay
                logic [VERTICAL_BW-1:0] r_dl [c_D];
                always_ff @(posedge clk) begin
                    if (!rst) begin
                        for (int d = 0; d < c_D; d++) r_dl[d] <= '0;
                    end else begin
                        r_dl[0] <= arr_op[gj*VERTICAL_BW +: VERTICAL_BW];
                        for (int d = 1; d < c_D; d++) r_dl[d] <= r_dl[d-1];
                    end
                end
                assign w_aligned[gj*VERTICAL_BW +: VERTICAL_BW] = r_dl[c_D-1];
            end
        end
    endgenerate

`ifdef PERF_CNT_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_stalls;
    logic        w_stall;

    assign w_stall = ((r_state == S_LOAD) && !w_valid) || ((r_state == S_STREAM) && !a_valid);

    always_ff @(posedge clk) begin
        if (!rst || (r_state == S_CLR)) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (busy && (r_perf_cycles != 32'hFFFF_FFFF)) r_perf_cycles <= r_perf_cycles + 32'd1;
            if (w_stall && (r_perf_stalls != 32'hFFFF_FFFF)) r_perf_stalls <= r_perf_stalls + 32'd1;
        end
    end

    assign perf_cycles = r_perf_cycles;
    assign perf_stalls = r_perf_stalls;
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_ctrl
// Brief    : Self-checking bench for systolic_ctrl with a behavioural array model.
// Revision : 1.0
// ============================================================================
module tb_systolic_ctrl;
    localparam int N       = 4;
    localparam int HBW     = 16;
    localparam int VBW     = 32;
    localparam int KW      = 16;
    localparam int OUT_LAT = 8;
    localparam int LAT     = OUT_LAT + N - 1;
    localparam int NJOBS   = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [KW-1:0]    k_len = '0;
    logic             busy, done, w_ready, a_ready, arr_mode, arr_rst, res_valid;
    logic             w_valid = 1'b0;
    logic             a_valid = 1'b0;
    logic [N*HBW-1:0] w_data = '0;
    logic [N*HBW-1:0] a_data = '0;
    logic [N*HBW-1:0] arr_vert, arr_horiz;
    logic [N*VBW-1:0] arr_op = '0;
    logic [N*VBW-1:0] res_data;
`ifdef PERF_CNT_EN
    logic [31:0]      perf_cycles, perf_stalls;
`endif

    systolic_ctrl #(
        .ARR_SIZE(N), .HORIZONTAL_BW(HBW), .VERTICAL_BW(VBW), .KW(KW), .OUT_LAT(OUT_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy), .done(done),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .arr_mode(arr_mode), .arr_rst(arr_rst), .arr_vert(arr_vert), .arr_horiz(arr_horiz),
        .arr_op(arr_op), .res_valid(res_valid), .res_data(res_data)
`ifdef PERF_CNT_EN
        , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*VBW-1:0] data;
        int               due;
    } exp_t;

    typedef struct {
        int kl;
        int wsel;
        bit wbub;
        int stall_at;
        int stall_len;
        int poke;
        int exp_res;
        int exp_stalls;
        bit chk_done_lat;
    } job_t;

    exp_t              sb[$];
    exp_t              me;
    job_t              jobs[NJOBS];
    int                errors = 0;
    int                checks = 0;
    int                cyc = 100;
    int                mode_cnt, res_cnt, done_cnt, lastw_cyc, done_cyc;
    logic [N*HBW-1:0]  hist [64];
    logic [HBW-1:0]    wm [N][N];
    logic [VBW-1:0]    macc, opacc;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N*HBW-1:0] wrow(input int sel, input int b);
        logic [N*HBW-1:0] r;
        r = '0;
        if (b < N) begin
            if (sel == 0) r[(N-1-b)*HBW +: HBW] = 16'd1;
            else          r[b*HBW +: HBW]       = 16'd1;
        end
        return r;
    endfunction

    function automatic logic [N*HBW-1:0] arow(input int base, input int k);
        logic [N*HBW-1:0] r;
        for (int i = 0; i < N; i++) r[i*HBW +: HBW] = HBW'(base * 256 + 4 * k + i);
        return r;
    endfunction

    // Array model: weights shift down on arr_mode; column j at cycle t sums row i input from t-OUT_LAT-j+i.
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        for (int j = 0; j < N; j++) begin
            opacc = '0;
            for (int i = 0; i < N; i++)
                opacc = opacc + VBW'(hist[(cyc - OUT_LAT - j + i) % 64][i*HBW +: HBW]) * VBW'(wm[i][j]);
            arr_op[j*VBW +: VBW] = opacc;
        end
    end

    always @(negedge clk) begin
        hist[cyc % 64] = arr_horiz;
        if (arr_mode) begin
            mode_cnt++;
            lastw_cyc = cyc;
            for (int r = N - 1; r > 0; r--)
                for (int c = 0; c < N; c++) wm[r][c] = wm[r-1][c];
            for (int c = 0; c < N; c++) wm[0][c] = arr_vert[c*HBW +: HBW];
        end
        if (a_valid && a_ready) begin
            me.data = '0;
            for (int j = 0; j < N; j++) begin
                macc = '0;
                for (int i = 0; i < N; i++) macc = macc + VBW'(a_data[i*HBW +: HBW]) * VBW'(wm[i][j]);
                me.data[j*VBW +: VBW] = macc;
            end
            me.due = cyc + LAT;
            sb.push_back(me);
        end
        if (res_valid) begin
            res_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got res_valid=1 data %0h expected no result (cycle %0d)", res_data, cyc);
            end else begin
                me = sb.pop_front();
                check("res_data", res_data, me.data);
                check("res_latency", cyc, me.due);
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (!rst) sb.delete();
    end

    task automatic run_job(input job_t j, input int base);
        int wb = 0;
        int ab = 0;
        int sc = 0;
        bit tog = 1'b1;
        bit dn = 1'b0;
        k_len   = KW'(j.kl);
        start   = 1'b1;
        w_valid = 1'b1;
        w_data  = wrow(j.wsel, 0);
        a_valid = 1'b0;
        for (int c = 0; c < 300 && !dn; c++) begin
            @(negedge clk);
            if (w_valid && w_ready) wb++;
            if (a_valid && a_ready) ab++;
            if (done) dn = 1'b1;
            @(posedge clk);
            #1;
            start = (c == j.poke);
            if (c == j.poke) k_len = KW'(9);
            tog     = !tog;
            w_valid = (wb < N) && (!j.wbub || tog);
            w_data  = wrow(j.wsel, wb);
            if (wb == N && ab == j.stall_at && sc < j.stall_len) begin
                a_valid = 1'b0;
                sc++;
            end else begin
                a_valid = (wb == N) && (ab < j.kl);
            end
            a_data = arow(base, ab);
        end
        if (!dn) begin
            checks++;
            errors++;
            $display("FAIL job_timeout: got no done expected done within 300 cycles");
        end
    endtask

    task automatic do_job(input job_t j, input int base);
        mode_cnt  = 0;
        res_cnt   = 0;
        done_cnt  = 0;
        done_cyc  = -1;
        lastw_cyc = -1;
        run_job(j, base);
        repeat (4) @(negedge clk);
        check("res_beats", res_cnt, j.exp_res);
        check("mode_cycles", mode_cnt, N);
        check("done_pulses", done_cnt, 1);
        check("sb_empty", sb.size(), 0);
        check("idle_busy", busy, 1'b0);
        if (j.chk_done_lat) check("done_latency", done_cyc, lastw_cyc + 1);
`ifdef PERF_CNT_EN
        if (j.exp_stalls >= 0) check("perf_stalls", perf_stalls, j.exp_stalls);
`endif
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin : main
        int wb;
        int ab;
        for (int i = 0; i < 64; i++) hist[i] = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) wm[r][c] = '0;

        jobs[0] = '{kl:4, wsel:0, wbub:0, stall_at:-1, stall_len:0, poke:-1, exp_res:4, exp_stalls:0, chk_done_lat:0};
        jobs[1] = '{kl:3, wsel:0, wbub:0, stall_at:2,  stall_len:2, poke:-1, exp_res:3, exp_stalls:2, chk_done_lat:0};
        jobs[2] = '{kl:0, wsel:0, wbub:0, stall_at:-1, stall_len:0, poke:-1, exp_res:0, exp_stalls:0, chk_done_lat:1};
        jobs[3] = '{kl:4, wsel:0, wbub:1, stall_at:-1, stall_len:0, poke:-1, exp_res:4, exp_stalls:-1, chk_done_lat:0};
        jobs[4] = '{kl:4, wsel:1, wbub:0, stall_at:-1, stall_len:0, poke:5,  exp_res:4, exp_stalls:0, chk_done_lat:0};
        jobs[5] = '{kl:6, wsel:1, wbub:0, stall_at:0,  stall_len:3, poke:-1, exp_res:6, exp_stalls:3, chk_done_lat:0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_w_ready", w_ready, 1'b0);
        check("rst_a_ready", a_ready, 1'b0);
        check("rst_arr_mode", arr_mode, 1'b0);
        check("rst_arr_rst", arr_rst, 1'b1);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_arr_vert", arr_vert, '0);
        check("rst_arr_horiz", arr_horiz, '0);
        check("rst_res_data", res_data, '0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int jn = 0; jn < NJOBS; jn++) do_job(jobs[jn], jn);

        // Reset three cycles into a stream must abort silently.
        k_len   = KW'(6);
        start   = 1'b1;
        w_valid = 1'b1;
        w_data  = wrow(0, 0);
        wb = 0;
        ab = 0;
        done_cnt = 0;
        for (int c = 0; c < 60 && ab < 3; c++) begin
            @(negedge clk);
            if (w_valid && w_ready) wb++;
            if (a_valid && a_ready) ab++;
            @(posedge clk);
            #1;
            start   = 1'b0;
            w_valid = (wb < N);
            w_data  = wrow(0, wb);
            a_valid = (wb == N);
            a_data  = arow(7, ab);
        end
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_res_valid", res_valid, 1'b0);
        check("midrst_arr_rst", arr_rst, 1'b1);
        check("midrst_a_ready", a_ready, 1'b0);
        check("midrst_arr_horiz", arr_horiz, '0);
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b1;
        a_valid = 1'b0;
        w_valid = 1'b0;
        @(negedge clk);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_arr_rst", arr_rst, 1'b0);
        repeat (20) @(negedge clk);
        check("post_rst_done", done_cnt, 0);
        @(posedge clk);
        #1;
        do_job(jobs[0], 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
